// File: rtl/regfile_pkg.sv
// Shared constants for the host-side register responder.
// Holds the block codes, the register offsets that the decoder and the read mux
// both need, the responder state type and the bit positions of the command strobes.
package regfile_pkg;

   localparam logic [3:0] BLK_GEN  = 4'h0;
   localparam logic [3:0] BLK_CONV = 4'h1;
   localparam logic [3:0] BLK_POOL = 4'h2;
   localparam logic [3:0] BLK_NL   = 4'h3;
   localparam logic [3:0] BLK_FC   = 4'h4;

   localparam logic [7:0] OFF_GEN_LAYER     = 8'h01;
   localparam logic [7:0] OFF_GEN_CFG_LAST  = 8'h0B;
   localparam logic [7:0] OFF_GEN_STATUS    = 8'h40;
   localparam logic [7:0] OFF_GEN_BUFFER    = 8'h41;
   localparam logic [7:0] OFF_GEN_CMD       = 8'h80;

   localparam logic [7:0] OFF_CONV_STRIDE   = 8'h08;
   localparam logic [7:0] OFF_CONV_CFG_LAST = 8'h0E;
   localparam logic [7:0] OFF_CONV_CIN      = 8'h0F;
   localparam logic [7:0] OFF_CONV_COUT     = 8'h10;
   localparam logic [7:0] OFF_CONV_STATUS   = 8'h11;

   localparam logic [7:0] OFF_POOL_LAST     = 8'h04;
   localparam logic [7:0] OFF_NL_LAST       = 8'h02;
   localparam logic [7:0] OFF_FC_LAST       = 8'h04;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;
   typedef enum logic [0:0] {IDLE = S_IDLE, RESP = S_RESP} state_t;

   localparam int CMD_W              = 10;
   localparam int CMD_START          = 0;
   localparam int CMD_ABRUPT_END     = 1;
   localparam int CMD_RESET          = 2;
   localparam int CMD_DIGITAL_RESET  = 3;
   localparam int CMD_FLUSH_BUFF1    = 4;
   localparam int CMD_FLUSH_BUFF2    = 5;
   localparam int CMD_LOAD_BUFF1     = 6;
   localparam int CMD_LOAD_BUFF2     = 7;
   localparam int CMD_START_LOADING  = 8;
   localparam int CMD_START_SAVING   = 9;

   function automatic logic in_range(input logic [7:0] off, input logic [7:0] lo,
                                     input logic [7:0] hi);
      return (off >= lo) && (off <= hi);
   endfunction

endpackage

// File: rtl/interface_regfile.sv
// Register-file bundle between the host responder and the accelerator core.
// Config fields and command strobes are driven by the responder; status fields
// are driven by the core and only sampled by the responder.
interface interface_regfile;
   logic [3:0]        store_to;
   logic [11:0]       layer_type;
   logic [11:2][15:0] gen_cfg;
   logic [14:1][15:0] conv_cfg;
   logic [7:0]        stride_horiz;
   logic [7:0]        stride_vert;
   logic [4:1][15:0]  pool_cfg;
   logic [2:1][15:0]  nl_cfg;
   logic [4:1][15:0]  fc_cfg;

   logic start_wr,                start_wr_en;
   logic abrupt_end_wr,           abrupt_end_wr_en;
   logic reset_wr,                reset_wr_en;
   logic digital_reset_wr,        digital_reset_wr_en;
   logic flush_buff1_wr,          flush_buff1_wr_en;
   logic flush_buff2_wr,          flush_buff2_wr_en;
   logic load_buff1_wr,           load_buff1_wr_en;
   logic load_buff2_wr,           load_buff2_wr_en;
   logic start_loading_buffer_wr, start_loading_buffer_wr_en;
   logic start_saving_buffer_wr,  start_saving_buffer_wr_en;

   logic [15:0] general__status;
   logic        buffer_saved;
   logic        buffer_loaded;
   logic [15:0] cin;
   logic [15:0] cout;
   logic [3:0]  conv__status;

   modport host (
      output store_to, layer_type, gen_cfg, conv_cfg, stride_horiz, stride_vert,
             pool_cfg, nl_cfg, fc_cfg,
             start_wr, start_wr_en, abrupt_end_wr, abrupt_end_wr_en,
             reset_wr, reset_wr_en, digital_reset_wr, digital_reset_wr_en,
             flush_buff1_wr, flush_buff1_wr_en, flush_buff2_wr, flush_buff2_wr_en,
             load_buff1_wr, load_buff1_wr_en, load_buff2_wr, load_buff2_wr_en,
             start_loading_buffer_wr, start_loading_buffer_wr_en,
             start_saving_buffer_wr, start_saving_buffer_wr_en,
      input  general__status, buffer_saved, buffer_loaded, cin, cout, conv__status
   );
endinterface

// File: rtl/regfile_addr_decode.sv
// Combinational address decoder for the register map.
// Ports: addr in; hit (address is mapped), ro (read-only register), is_cmd (0x0080
// command register), block ([15:12]), offset ([7:0]). Any address with non-zero
// [11:8] is treated as unmapped.
module regfile_addr_decode
   import regfile_pkg::*;
(
   input  logic [15:0] addr,
   output logic        hit,
   output logic        ro,
   output logic        is_cmd,
   output logic [3:0]  block,
   output logic [7:0]  offset
);

   always_comb begin
      block  = addr[15:12];
      offset = addr[7:0];
      hit    = 1'b0;
      ro     = 1'b0;
      is_cmd = 1'b0;
      if (addr[11:8] == 4'h0) begin
         case (block)
            BLK_GEN: begin
               if (in_range(offset, OFF_GEN_LAYER, OFF_GEN_CFG_LAST)) begin
                  hit = 1'b1;
               end else if (offset == OFF_GEN_STATUS || offset == OFF_GEN_BUFFER) begin
                  hit = 1'b1;
                  ro  = 1'b1;
               end else if (offset == OFF_GEN_CMD) begin
                  hit    = 1'b1;
                  is_cmd = 1'b1;
               end
            end
            BLK_CONV: begin
               if (in_range(offset, 8'h01, OFF_CONV_CFG_LAST)) begin
                  hit = 1'b1;
               end else if (in_range(offset, OFF_CONV_CIN, OFF_CONV_STATUS)) begin
                  hit = 1'b1;
                  ro  = 1'b1;
               end
            end
            BLK_POOL: hit = in_range(offset, 8'h01, OFF_POOL_LAST);
            BLK_NL:   hit = in_range(offset, 8'h01, OFF_NL_LAST);
            BLK_FC:   hit = in_range(offset, 8'h01, OFF_FC_LAST);
            default:  hit = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/regfile_host_responder.sv
// Host-side responder for the accelerator register map.
// Accepts one valid/ready request at a time, performs writes on the accept edge,
// and returns one registered response per request.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_write/req_addr/
// req_wdata (request channel); resp_valid/resp_ready/resp_rdata/resp_err
// (response channel); regs (config/command outputs, status inputs).
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// RESP  | response registered and held until resp_ready
module regfile_host_responder
   import regfile_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   interface_regfile.host    regs
);

   state_t            state_q, state_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

   logic [15:0]       gen1_q, gen1_d;
   logic [11:2][15:0] gen_cfg_q, gen_cfg_d;
   logic [14:1][15:0] conv_cfg_q, conv_cfg_d;
   logic [4:1][15:0]  pool_cfg_q, pool_cfg_d;
   logic [2:1][15:0]  nl_cfg_q, nl_cfg_d;
   logic [4:1][15:0]  fc_cfg_q, fc_cfg_d;
   logic [CMD_W-1:0]  cmd_wr_q, cmd_wr_d;
   logic [CMD_W-1:0]  cmd_wr_en_q, cmd_wr_en_d;

   logic              dec_hit, dec_ro, dec_is_cmd;
   logic [3:0]        dec_block;
   logic [7:0]        dec_offset;
   logic              accept, wr_ok;
   logic [15:0]       rd_mux;

   regfile_addr_decode u_decode (
      .addr   (req_addr),
      .hit    (dec_hit),
      .ro     (dec_ro),
      .is_cmd (dec_is_cmd),
      .block  (dec_block),
      .offset (dec_offset)
   );

   assign accept = req_valid && (state_q == IDLE);
   assign wr_ok  = accept && req_write && dec_hit && !dec_ro;

   // Index widths below are sized to each array; the decoder guarantees the
   // offset is inside the array range whenever dec_hit is set.
   always_comb begin
      rd_mux = '0;
      if (dec_hit && !dec_is_cmd) begin
         case (dec_block)
            BLK_GEN: begin
               if (dec_offset == OFF_GEN_LAYER)       rd_mux = gen1_q;
               else if (dec_offset == OFF_GEN_STATUS) rd_mux = regs.general__status;
               else if (dec_offset == OFF_GEN_BUFFER) rd_mux = {14'b0, regs.buffer_saved,
                                                                regs.buffer_loaded};
               else                                   rd_mux = gen_cfg_q[dec_offset[3:0]];
            end
            BLK_CONV: begin
               if (dec_offset == OFF_CONV_CIN)         rd_mux = regs.cin;
               else if (dec_offset == OFF_CONV_COUT)   rd_mux = regs.cout;
               else if (dec_offset == OFF_CONV_STATUS) rd_mux = {12'b0, regs.conv__status};
               else                                    rd_mux = conv_cfg_q[dec_offset[3:0]];
            end
            BLK_POOL: rd_mux = pool_cfg_q[dec_offset[2:0]];
            BLK_NL:   rd_mux = nl_cfg_q[dec_offset[1:0]];
            BLK_FC:   rd_mux = fc_cfg_q[dec_offset[2:0]];
            default:  rd_mux = '0;
         endcase
      end
   end

   always_comb begin
      gen1_d      = gen1_q;
      gen_cfg_d   = gen_cfg_q;
      conv_cfg_d  = conv_cfg_q;
      pool_cfg_d  = pool_cfg_q;
      nl_cfg_d    = nl_cfg_q;
      fc_cfg_d    = fc_cfg_q;
      cmd_wr_d    = cmd_wr_q;
      cmd_wr_en_d = '0;
      if (wr_ok) begin
         if (dec_is_cmd) begin
            cmd_wr_d    = req_wdata[CMD_W-1:0];
            cmd_wr_en_d = '1;
         end else begin
            case (dec_block)
               BLK_GEN: begin
                  if (dec_offset == OFF_GEN_LAYER) gen1_d = req_wdata;
                  else                             gen_cfg_d[dec_offset[3:0]] = req_wdata;
               end
               BLK_CONV: conv_cfg_d[dec_offset[3:0]] = req_wdata;
               BLK_POOL: pool_cfg_d[dec_offset[2:0]] = req_wdata;
               BLK_NL:   nl_cfg_d[dec_offset[1:0]]   = req_wdata;
               BLK_FC:   fc_cfg_d[dec_offset[2:0]]   = req_wdata;
               default:  ;
            endcase
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = !dec_hit || (req_write && dec_ro);
               resp_rdata_d = (!req_write && dec_hit) ? rd_mux : '0;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         gen1_q       <= '0;
         gen_cfg_q    <= '0;
         conv_cfg_q   <= '0;
         pool_cfg_q   <= '0;
         nl_cfg_q     <= '0;
         fc_cfg_q     <= '0;
         cmd_wr_q     <= '0;
         cmd_wr_en_q  <= '0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         gen1_q       <= gen1_d;
         gen_cfg_q    <= gen_cfg_d;
         conv_cfg_q   <= conv_cfg_d;
         pool_cfg_q   <= pool_cfg_d;
         nl_cfg_q     <= nl_cfg_d;
         fc_cfg_q     <= fc_cfg_d;
         cmd_wr_q     <= cmd_wr_d;
         cmd_wr_en_q  <= cmd_wr_en_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

   assign regs.store_to     = gen1_q[15:12];
   assign regs.layer_type   = gen1_q[11:0];
   assign regs.gen_cfg      = gen_cfg_q;
   assign regs.conv_cfg     = conv_cfg_q;
   assign regs.stride_horiz = conv_cfg_q[OFF_CONV_STRIDE[3:0]][15:8];
   assign regs.stride_vert  = conv_cfg_q[OFF_CONV_STRIDE[3:0]][7:0];
   assign regs.pool_cfg     = pool_cfg_q;
   assign regs.nl_cfg       = nl_cfg_q;
   assign regs.fc_cfg       = fc_cfg_q;

   assign regs.start_wr                   = cmd_wr_q[CMD_START];
   assign regs.abrupt_end_wr              = cmd_wr_q[CMD_ABRUPT_END];
   assign regs.reset_wr                   = cmd_wr_q[CMD_RESET];
   assign regs.digital_reset_wr           = cmd_wr_q[CMD_DIGITAL_RESET];
   assign regs.flush_buff1_wr             = cmd_wr_q[CMD_FLUSH_BUFF1];
   assign regs.flush_buff2_wr             = cmd_wr_q[CMD_FLUSH_BUFF2];
   assign regs.load_buff1_wr              = cmd_wr_q[CMD_LOAD_BUFF1];
   assign regs.load_buff2_wr              = cmd_wr_q[CMD_LOAD_BUFF2];
   assign regs.start_loading_buffer_wr    = cmd_wr_q[CMD_START_LOADING];
   assign regs.start_saving_buffer_wr     = cmd_wr_q[CMD_START_SAVING];

   assign regs.start_wr_en                = cmd_wr_en_q[CMD_START];
   assign regs.abrupt_end_wr_en           = cmd_wr_en_q[CMD_ABRUPT_END];
   assign regs.reset_wr_en                = cmd_wr_en_q[CMD_RESET];
   assign regs.digital_reset_wr_en        = cmd_wr_en_q[CMD_DIGITAL_RESET];
   assign regs.flush_buff1_wr_en          = cmd_wr_en_q[CMD_FLUSH_BUFF1];
   assign regs.flush_buff2_wr_en          = cmd_wr_en_q[CMD_FLUSH_BUFF2];
   assign regs.load_buff1_wr_en           = cmd_wr_en_q[CMD_LOAD_BUFF1];
   assign regs.load_buff2_wr_en           = cmd_wr_en_q[CMD_LOAD_BUFF2];
   assign regs.start_loading_buffer_wr_en = cmd_wr_en_q[CMD_START_LOADING];
   assign regs.start_saving_buffer_wr_en  = cmd_wr_en_q[CMD_START_SAVING];

endmodule
